uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Register-mapped UART transmitter; the transmit-side counterpart of the uart receiver.
//  Sits on the same we/reg_num/wd store bus and serialises bytes onto tx as 8N1 frames.
//  Bytes are sent LSB first.
//  An internal FIFO decouples CPU stores from the bit timing.
// PARAMETERS
//  DEPTH        4        FIFO entries; must be a power of 2 and >= 2
//  DIV_RESET    16'd867  baud divisor after reset; clocks per bit = DIV+1
// PORTS
//  clk      in   1   system clock, rising edge
//  rst_n    in   1   asynchronous active-low reset
//  we       in   1   register write strobe; sampled on rising clk
//  reg_num  in   3   register select
//  wd       in   32  write data
//  rd       out  32  read data for reg_num; combinational
//  tx       out  1   serial line, idle high
//  irq      out  1   high while tx_en=1, FIFO empty and FSM in IDLE
// BEHAVIOUR
//  Registers:
//   - 0 CTRL (rw): bit0 tx_en; other bits read 0.
//   - 1 STATUS (ro): bit0 busy (FSM!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky).
//     Any write to reg 1 clears overflow.
//   - 2 BAUD (rw): bits[15:0] divisor.
//   - 3 DATA (wo): write pushes wd[7:0] into the FIFO; reads return 0.
//   - 4..7: writes are ignored, reads return 0.
//  Reset values: tx=1, CTRL=0, BAUD=DIV_RESET, FIFO empty, overflow=0, FSM=IDLE, irq=0.
//  Reset is asynchronous at any time, including mid-frame: tx goes high immediately and
//  queued bytes are discarded.
//  FSM states IDLE, START, DATA, STOP. Bit counter 0..7, baud counter 0..div.
//   - IDLE:
//     - If tx_en=1 and FIFO is non-empty: pop into the shift register, latch BAUD into div,
//       and go to START on the same edge.
//     - A byte written while in IDLE with tx_en=1 is popped on the following edge.
//       tx falls 2 clocks after the DATA write edge.
//   - START: tx=0 for div+1 clocks, then go to DATA with bit=0.
//   - DATA: tx=shift[0] for div+1 clocks; then shift right and increment bit.
//     After bit 7 has been sent, go to STOP.
//   - STOP: tx=1 for div+1 clocks. On the last clock:
//     - if tx_en=1 and FIFO is non-empty: pop, relatch div, go to START (no idle gap between frames);
//     - otherwise go to IDLE.
//  Timing and edge cases:
//   - Frame length is exactly 10*(div+1) clocks.
//   - A BAUD write mid-frame does not affect the current frame; it takes effect at the next pop.
//   - Clearing tx_en mid-frame lets the current frame complete, then no further pops.
//   - DATA write with FIFO full and no pop on the same edge: byte dropped, overflow set.
//   - DATA write with FIFO full and a pop on the same edge: accepted; FIFO stays full.
//   - DATA write with FIFO empty and a pop on the same edge is impossible, because the pop
//     needs non-empty. The byte is queued and popped on a later edge.
//   - FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally.
//     full = MSBs differ and the rest are equal; empty = pointers equal.
//   - BAUD=0 is legal: 1 clock per bit.
// TESTING (clk period 2 ns)
//  1. Reset, then BAUD=1, CTRL=1, DATA=0x7F -> tx low 4 ns (start), then 1,1,1,1,1,1,1,0
//     at 4 ns/bit, then stop high. busy=1 during the frame; irq=1 after the frame.
//  2. BAUD=0, write 0x55 then 0xA3 back-to-back -> 20 clocks continuous:
//     0,1,0,1,0,1,0,1,0,1, 0,1,1,0,0,0,1,0,1,1, with no idle clock between frames.
//  3. CTRL=0, write DEPTH+1=5 bytes -> STATUS=0x0A (full, overflow).
//     Write reg1 -> STATUS=0x02. Then CTRL=1 -> exactly 4 frames sent; first 4 bytes in order.
//  4. BAUD=3, start 0x0F, write BAUD=0 during DATA -> all 10 bits of frame 1 last 4 clocks;
//     next frame uses 1 clock/bit.
//  5. rst_n low during bit 3 of a frame -> tx=1 asynchronously, STATUS=0x04, CTRL=0,
//     BAUD=867; no frame after release.
//  6. Reads: reg 2 after BAUD=0x1234 -> rd=0x00001234; reg 3 and reg 5 -> rd=0;
//     write to reg 6 leaves all state unchanged.

Source files
------------

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// Register-mapped UART transmitter: CPU stores on the we/reg_num/wd bus feed a small FIFO,
// which drains onto tx as 8N1 frames, LSB first, at DIV+1 clocks per bit.
module uart_tx #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  reg_num,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_q,   bit_d;
  logic [15:0]   cnt_q,   cnt_d;
  logic [15:0]   div_q,   div_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q,    tx_d;
  logic          tx_en_q, tx_en_d;
  logic [15:0]   baud_q,  baud_d;
  logic          ovf_q,   ovf_d;
  logic [PW-1:0] wptr_q,  wptr_d;
  logic [PW-1:0] rptr_q,  rptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic wr_ctrl_s, wr_stat_s, wr_baud_s, wr_data_s;
  logic full_s, empty_s, busy_s, last_s, pop_s, push_s;
  logic [7:0] head_s;
  logic unused_s;

  assign wr_ctrl_s = we && (reg_num == 3'd0);
  assign wr_stat_s = we && (reg_num == 3'd1);
  assign wr_baud_s = we && (reg_num == 3'd2);
  assign wr_data_s = we && (reg_num == 3'd3);
  assign unused_s  = ^wd[31:16];

  assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_s = (wptr_q == rptr_q);
  assign busy_s  = (state_q != S_IDLE);
  assign last_s  = (cnt_q == div_q);
  assign head_s  = mem_q[rptr_q[AW-1:0]];

  // A pop happens from IDLE, or on the final STOP clock so frames run back to back.
  assign pop_s  = tx_en_q && !empty_s &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && last_s));
  assign push_s = wr_data_s && (!full_s || pop_s);

  assign tx  = tx_q;
  assign irq = tx_en_q && empty_s && !busy_s;

  // Register file and FIFO bookkeeping.
  always_comb begin
    tx_en_d = wr_ctrl_s ? wd[0] : tx_en_q;
    baud_d  = wr_baud_s ? wd[15:0] : baud_q;
    if (wr_stat_s) begin
      ovf_d = 1'b0;
    end else if (wr_data_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    wptr_d = push_s ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + PTR_ONE) : rptr_q;
    mem_d  = mem_q;
    if (push_s) begin
      mem_d[wptr_q[AW-1:0]] = wd[7:0];
    end else begin
      mem_d[wptr_q[AW-1:0]] = mem_q[wptr_q[AW-1:0]];
    end
  end

  // Frame sequencer; the divisor is captured at each pop so BAUD writes never disturb a frame.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (pop_s) begin
          shift_d = head_s;
          div_d   = baud_q;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (last_s) begin
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (last_s) begin
          cnt_d   = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (last_s) begin
          cnt_d = 16'd0;
          if (pop_s) begin
            shift_d = head_s;
            div_d   = baud_q;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // tx is registered, so the line trails the state by one clock.
  always_comb begin
    case (state_q)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Combinational read mux.
  always_comb begin
    case (reg_num)
      3'd0:    rd = {31'd0, tx_en_q};
      3'd1:    rd = {28'd0, ovf_q, empty_s, full_s, busy_s};
      3'd2:    rd = {16'd0, baud_q};
      default: rd = 32'd0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= 3'd0;
      cnt_q   <= 16'd0;
      div_q   <= DIV_RESET;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      tx_en_q <= 1'b0;
      baud_q  <= DIV_RESET;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      tx_en_q <= tx_en_d;
      baud_q  <= baud_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// Directed bench for uart_tx: bytes are queued as expected when written and checked
// against frames decoded from tx.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  reg_num;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;
  logic        irq;

  int nvec = 0;
  int nmis = 0;
  logic [7:0] sb[$];

  uart_tx #(.DEPTH(4), .DIV_RESET(16'd867)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .reg_num(reg_num), .wd(wd),
    .rd(rd), .tx(tx), .irq(irq)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus write; called just after a falling edge, returns just after the next one.
  task automatic wr(input logic [2:0] r, input logic [31:0] d);
    we = 1'b1; reg_num = r; wd = d;
    @(negedge clk);
    we = 1'b0; reg_num = 3'd1; wd = 32'd0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    if (accept) sb.push_back(b);
    wr(3'd3, {24'd0, b});
  endtask

  task automatic rdchk(input string tag, input logic [2:0] r, input logic [31:0] exp);
    reg_num = r;
    #0.2;
    chk(tag, rd, exp);
    reg_num = 3'd1;
  endtask

  // Decode one frame sampling at falling edges; every sample of a bit must agree.
  task automatic get_frame(input int div, input int act_at, output logic [7:0] data,
                           output int waits, output logic busy_seen, output bit ok);
    logic [9:0] bits;
    int n;
    ok = 1'b1; waits = 0; data = 8'd0; busy_seen = 1'b0; bits = 10'd0;
    do begin
      @(negedge clk);
      waits++;
    end while (tx !== 1'b0 && waits < 2000);
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    busy_seen = rd[0];
    n = 0;
    for (int b = 0; b < 10; b++) begin
      for (int s = 0; s <= div; s++) begin
        if (!(b == 0 && s == 0)) @(negedge clk);
        if (n == act_at) begin
          we = 1'b1; reg_num = 3'd2; wd = 32'd0;
        end else if (n == act_at + 1) begin
          we = 1'b0; reg_num = 3'd1; wd = 32'd0;
        end
        if (s == 0) bits[b] = tx;
        else if (tx !== bits[b]) ok = 1'b0;
        n++;
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    data = bits[8:1];
  endtask

  task automatic recv(input string tag, input int div, input int act_at, input int exp_waits);
    logic [7:0] data;
    int waits;
    logic busy;
    bit ok;
    logic [8:0] exp;
    get_frame(div, act_at, data, waits, busy, ok);
    chk({tag, "_ok"}, {31'd0, ok}, 32'd1);
    exp = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
    chk({tag, "_data"}, {24'd0, data}, {23'd0, exp});
    if (exp_waits >= 0) chk({tag, "_lat"}, waits, exp_waits);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit q;
    q = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1) q = 1'b0;
    end
    chk(tag, {31'd0, q}, 32'd1);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; we = 1'b0; reg_num = 3'd1; wd = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rdchk("rst_ctrl", 3'd0, 32'd0);
    rdchk("rst_status", 3'd1, 32'h04);
    rdchk("rst_baud", 3'd2, 32'd867);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, 2 clocks per bit.
    wr(3'd2, 32'd1);
    wr(3'd0, 32'd1);
    push_byte(8'h7F, 1'b1);
    recv("t1", 1, -1, 2);
    @(negedge clk);
    chk("t1_irq", {31'd0, irq}, 32'd1);
    rdchk("t1_status", 3'd1, 32'h04);

    // Back-to-back frames at 1 clock per bit with no idle gap.
    wr(3'd2, 32'd0);
    push_byte(8'h55, 1'b1);
    push_byte(8'hA3, 1'b1);
    recv("t2a", 0, -1, 1);
    recv("t2b", 0, -1, 1);

    // Overflow with transmitter disabled, then drain.
    wr(3'd0, 32'd0);
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    push_byte(8'h99, 1'b0);
    rdchk("t3_status_ovf", 3'd1, 32'h0A);
    wr(3'd1, 32'd0);
    rdchk("t3_status_clr", 3'd1, 32'h02);
    wr(3'd0, 32'd1);
    recv("t3a", 0, -1, 2);
    recv("t3b", 0, -1, 1);
    recv("t3c", 0, -1, 1);
    recv("t3d", 0, -1, 1);
    quiet("t3_no_fifth", 30);
    chk("t3_irq", {31'd0, irq}, 32'd1);
    rdchk("t3_status_end", 3'd1, 32'h04);

    // BAUD change mid-frame only affects the following frame.
    wr(3'd2, 32'd3);
    push_byte(8'h0F, 1'b1);
    push_byte(8'h3C, 1'b1);
    recv("t4a", 3, 8, 1);
    recv("t4b", 0, -1, 1);
    rdchk("t4_baud", 3'd2, 32'd0);

    // Asynchronous reset during bit 3 of a frame, with a byte still queued.
    wr(3'd2, 32'd1);
    push_byte(8'hA5, 1'b1);
    push_byte(8'h11, 1'b1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx !== 1'b0 && w < 100);
    chk("t5_start", {31'd0, tx}, 32'd0);
    repeat (8) @(negedge clk);
    chk("t5_bit3", {31'd0, tx}, 32'd0);
    #0.5;
    rst_n = 1'b0;
    #0.2;
    chk("t5_async_tx", {31'd0, tx}, 32'd1);
    chk("t5_irq", {31'd0, irq}, 32'd0);
    rdchk("t5_status", 3'd1, 32'h04);
    rdchk("t5_ctrl", 3'd0, 32'd0);
    rdchk("t5_baud", 3'd2, 32'd867);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    quiet("t5_no_frame", 40);
    rdchk("t5_status_after", 3'd1, 32'h04);

    // Read decoding and ignored registers.
    wr(3'd2, 32'h1234);
    rdchk("t6_baud", 3'd2, 32'h00001234);
    rdchk("t6_reg3", 3'd3, 32'd0);
    rdchk("t6_reg5", 3'd5, 32'd0);
    wr(3'd6, 32'hFFFF_FFFF);
    rdchk("t6_ctrl_kept", 3'd0, 32'd0);
    rdchk("t6_status_kept", 3'd1, 32'h04);
    rdchk("t6_baud_kept", 3'd2, 32'h00001234);
    chk("t6_tx_kept", {31'd0, tx}, 32'd1);
    wr(3'd0, 32'hFFFF_FFFF);
    rdchk("t6_ctrl_mask", 3'd0, 32'd1);
    rdchk("t6_reg7", 3'd7, 32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
